// File: rtl/cbus_rr_arbiter.sv
// N-port cache-bus arbiter toward the AXI bridge.
// Grants one master per burst (round-robin or fixed priority), holds the
// grant until the last response beat and flags burst-length violations.

package cbus_pkg;

  typedef logic [7:0] mlen_t;

  // Burst length is encoded as number of beats minus one.
  localparam mlen_t MLEN1  = 8'd0;
  localparam mlen_t MLEN2  = 8'd1;
  localparam mlen_t MLEN4  = 8'd3;
  localparam mlen_t MLEN8  = 8'd7;
  localparam mlen_t MLEN16 = 8'd15;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    mlen_t       len;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] rdata;
  } cbus_resp_t;

endpackage

module cbus_rr_arbiter
  import cbus_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int RR_MODE   = 1,
  parameter int IDX_W     = ($clog2(NUM_PORTS) > 0) ? $clog2(NUM_PORTS) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  cbus_req_t        ireqs  [NUM_PORTS],
  output cbus_resp_t       iresps [NUM_PORTS],
  output cbus_req_t        oreq,
  input  cbus_resp_t       oresp,
  output logic             busy,
  output logic [IDX_W-1:0] grant_idx,
  output logic             err
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  mlen_t            beat_cnt_q, beat_cnt_d;
  logic             err_q, err_d;

  logic [IDX_W-1:0] win_idx;
  logic             win_found;
  logic [IDX_W-1:0] next_ptr;
  cbus_req_t        cur_req;

  // The granted master's request; only meaningful while BUSY.
  assign cur_req  = ireqs[sel_q];
  // Pointer for the next round-robin scan: just past the master served.
  assign next_ptr = IDX_W'((int'(sel_q) + 1) % NUM_PORTS);

  // Winner selection: scan from rr_ptr (round-robin) or from 0 (fixed priority).
  always_comb begin
    logic [IDX_W-1:0] cand;
    cand      = '0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (RR_MODE != 0) begin
        cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_PORTS);
      end else begin
        cand = IDX_W'(k);
      end
      if (!win_found && ireqs[cand].valid) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // State and bookkeeping registers; reset aborts any burst immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
    end
  end

  // Next-state: grant in IDLE, count beats in BUSY, release on the last beat.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Ready beats while idle are ignored entirely.
        if (win_found) begin
          sel_d      = win_idx;
          beat_cnt_d = '0;
          state_d    = S_BUSY;
        end
      end
      S_BUSY: begin
        // The grant is kept even if the master withdraws; that is only flagged.
        if (!cur_req.valid) begin
          err_d = 1'b1;
        end
        if (oresp.ready) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (oresp.last && (beat_cnt_q != cur_req.len)) begin
            err_d = 1'b1;
          end
          if (!oresp.last && (beat_cnt_q == cur_req.len)) begin
            err_d = 1'b1;
          end
          if (oresp.last) begin
            state_d    = S_IDLE;
            beat_cnt_d = '0;
            if (RR_MODE != 0) begin
              rr_ptr_d = next_ptr;
            end
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output routing: only the granted master sees the bridge, and only while BUSY.
  always_comb begin
    oreq = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      iresps[j] = '0;
    end
    if (state_q == S_BUSY) begin
      oreq          = cur_req;
      iresps[sel_q] = oresp;
    end
  end

  assign busy      = (state_q == S_BUSY);
  assign grant_idx = sel_q;
  assign err       = err_q;

endmodule
